bcd_counter_ctrl: RTL and testbench
===================================

Name: bcd_counter_ctrl

Overview:
- Controller for the two-digit push-button counter datapath.
- Debounces two raw buttons, inc and dec, and converts each into a single event per press.
- Arbitrates the two event streams onto one shared BCD count register (00..99), with round-robin priority on collisions.
- Presents tens/units BCD digits plus an update strobe to the downstream 7-segment decoders.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized-high samples needed to accept a press; also the consecutive-low samples needed to accept a release. Range 1..255.
- REPEAT_DELAY, 16, cycles a button is held in PRESSED before the first auto-repeat event (AUTOREPEAT_EN only).
- REPEAT_RATE, 8, cycles between subsequent auto-repeat events (AUTOREPEAT_EN only).
- CNT_W, 8, width of the internal debounce/repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- btn_inc  input  1  raw asynchronous increment button, active-high.
- btn_dec  input  1  raw asynchronous decrement button, active-high.
- tens  output  4  BCD tens digit, 0..9.
- units  output  4  BCD units digit, 0..9.
- update  output  1  one-cycle pulse; high in the cycle after tens/units change.
- grant_inc  output  1  one-cycle pulse; an inc event was applied this edge.
- grant_dec  output  1  one-cycle pulse; a dec event was applied this edge.

Behaviour:
- Reset (async, active-high): tens=0, units=0, update=0, grant_inc=0, grant_dec=0, synchronizers=0, debounce FSMs=IDLE, pending flags=0, priority pointer=INC.
- Synchronizer: each button passes a 2-flop synchronizer; only the synchronized value is used downstream.
- Per-button debounce FSM, four states:
  - IDLE: sync=1 -> ARM, count=1.
  - ARM: sync=1 -> count++; on count==DEBOUNCE_CYCLES -> PRESSED and emit one-cycle event. sync=0 -> IDLE, count=0.
  - PRESSED: sync=0 -> RELEASE, count=1.
  - RELEASE: sync=0 -> count++; on count==DEBOUNCE_CYCLES -> IDLE. sync=1 -> PRESSED.
- A pulse or bounce shorter than DEBOUNCE_CYCLES synchronized samples produces no event.
- One event per accepted press, regardless of hold time (without AUTOREPEAT_EN).
- Arbiter:
  - Only one event is applied per edge.
  - inc-only applies +1; dec-only applies -1.
  - Same-cycle collision: the side named by the priority pointer wins. The loser is latched in its one-deep pending flag and applied on the next edge. The pointer toggles after every collision.
  - Pending events are served before new events from the same side.
  - A new event arriving while that side's pending flag is set is dropped; this cannot occur when DEBOUNCE_CYCLES>=2.
- Counting: two-digit BCD arithmetic.
  - inc: units 9 -> 0 with tens+1; 99 -> 00.
  - dec: units 0 -> 9 with tens-1; 00 -> 99.
  - Digits never leave 0..9.
- Latency: raw edge first sampled at edge N -> event at edge N+1+DEBOUNCE_CYCLES -> count and grant_* at edge N+2+DEBOUNCE_CYCLES -> update high during the following cycle.
- Reset mid-press: all state clears immediately; a button still held after reset deasserts must debounce again from IDLE before it can generate an event.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- Defined:
  - While a debounce FSM stays in PRESSED, a repeat counter runs.
  - The first extra event fires REPEAT_DELAY cycles after entry to PRESSED.
  - Further events fire every REPEAT_RATE cycles.
  - Leaving PRESSED clears the repeat counter.
  - Repeat events go through the same arbiter and pending rules as normal events.
- Undefined: no repeat logic; exactly one event per press. REPEAT_DELAY and REPEAT_RATE are ignored.

Test Plan:
Common settings: DEBOUNCE_CYCLES=4, 10 ns clock.
1. Reset, then btn_inc held 100 ns -> exactly one grant_inc; tens=0, units=1; update pulses once, 7 cycles after the first sampling edge.
2. Bounce pattern on btn_inc (5 ns on/off x2, then 10 ns high, then low); 15 ns clean press -> no grant_inc; count stays 00.
3. Start from 09, press inc -> 10. Start from 99, press inc -> 00. Start from 00, press dec -> 99. Start from 10, press dec -> 09.
4. btn_inc and btn_dec rise on the same cycle, both held 100 ns, starting from 05:
   - grant_inc on edge K, grant_dec on edge K+1; final count 05.
   - Repeat the collision: grant_dec first (pointer toggled).
5. Hold btn_inc, assert reset for 2 cycles mid-hold, then release reset with btn_inc still high -> outputs 00 during reset; exactly one new increment, 7 cycles after reset release; count 01.
6. With AUTOREPEAT_EN (REPEAT_DELAY=16, REPEAT_RATE=8), hold btn_inc for 60 cycles after PRESSED entry -> 1 + 1 + 5 = 7 increments; count 07.

Source files
------------

// File: rtl/bcd_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_counter_ctrl
//  Purpose  : Controller for the two-digit push-button BCD counter.
//             - Two 2-flop synchronizers, one per raw button.
//             - One four-state debounce FSM per button that turns each
//               accepted press into a single one-cycle event.
//             - A round-robin arbiter that applies at most one event per
//               edge to a shared 00..99 BCD count. The loser of a collision
//               is held in a one-deep pending flag.
//             - Registered tens/units digits, grant pulses and an update
//               strobe for the downstream 7-segment decoders.
//  Options  : `define AUTOREPEAT_EN to enable auto-repeat while a button is
//             held (REPEAT_DELAY / REPEAT_RATE). Without it each press gives
//             exactly one event and both repeat parameters are ignored.
//  Ports    : clk        in   system clock, rising edge
//             reset      in   asynchronous reset, active high
//             btn_inc    in   raw increment button, active high
//             btn_dec    in   raw decrement button, active high
//             tens       out  [3:0] BCD tens digit
//             units      out  [3:0] BCD units digit
//             update     out  pulse, high in the cycle after a digit change
//             grant_inc  out  pulse, an increment was applied on this edge
//             grant_dec  out  pulse, a decrement was applied on this edge
//  Revision : 1.0  initial release
// ============================================================================
module bcd_counter_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 8,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       update,
    output logic       grant_inc,
    output logic       grant_dec
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("bcd_counter_ctrl: DEBOUNCE_CYCLES must be in 1..255");
    end
    if (DEBOUNCE_CYCLES >= (2 ** CNT_W) || REPEAT_DELAY >= (2 ** CNT_W) ||
        REPEAT_RATE >= (2 ** CNT_W) || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cnt_w
        $error("bcd_counter_ctrl: CNT_W too small or repeat timing out of range");
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_PRESSED = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic PTR_INC = 1'b0;
    localparam logic PTR_DEC = 1'b1;

    localparam logic [CNT_W-1:0] C_DEB = CNT_W'(DEBOUNCE_CYCLES);

    // Bit 0 carries the increment button, bit 1 the decrement button.
    localparam int BTN_INC = 0;
    localparam int BTN_DEC = 1;

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = {btn_dec, btn_inc};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce FSMs
    // ------------------------------------------------------------------
    logic [1:0] btn_ev;     // registered one-cycle events per button

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic [1:0]       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] cnt_inc;
        logic             hit;
        logic             sync;
        logic             press_ev;
        logic             rep_ev;
        logic             ev_q, ev_d;

        assign sync    = sync2_q[i];
        assign cnt_inc = cnt_q + CNT_W'(1);
        // The counter is zero in IDLE and PRESSED, so the same compare also
        // covers DEBOUNCE_CYCLES==1, where the first sample is enough.
        assign hit     = (cnt_inc >= C_DEB);

        // State register
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                ev_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ev_q    <= ev_d;
            end
        end

        // Next-state logic
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_IDLE: begin
                    if (sync) begin
                        state_d = hit ? ST_PRESSED : ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (!sync) begin
                        state_d = ST_IDLE;
                    end else if (hit) begin
                        state_d = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (!sync) begin
                        state_d = hit ? ST_IDLE : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (sync) begin
                        state_d = ST_PRESSED;
                    end else if (hit) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Output / datapath logic
        always_comb begin
            // The counter only runs while qualifying in ARM or RELEASE; any
            // entry into those states starts from zero, so +1 gives count=1.
            cnt_d    = (state_d == ST_ARM || state_d == ST_RELEASE) ? cnt_inc : '0;
            press_ev = (state_d == ST_PRESSED) &&
                       (state_q == ST_IDLE || state_q == ST_ARM);
            ev_d     = press_ev | rep_ev;
        end

`ifdef AUTOREPEAT_EN
        localparam logic [CNT_W-1:0] C_RDLY  = CNT_W'(REPEAT_DELAY);
        localparam logic [CNT_W-1:0] C_RRATE = CNT_W'(REPEAT_RATE);

        logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
        logic [CNT_W-1:0] rep_inc;
        logic             rep_phase_q, rep_phase_d;   // 0: waiting for first repeat

        assign rep_inc = rep_cnt_q + CNT_W'(1);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rep_cnt_q   <= '0;
                rep_phase_q <= 1'b0;
            end else begin
                rep_cnt_q   <= rep_cnt_d;
                rep_phase_q <= rep_phase_d;
            end
        end

        // The counter only runs while the FSM stays in PRESSED; entering or
        // leaving PRESSED leaves it cleared.
        always_comb begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
            rep_ev      = 1'b0;
            if (state_q == ST_PRESSED && state_d == ST_PRESSED) begin
                if (!rep_phase_q && rep_inc == C_RDLY) begin
                    rep_ev      = 1'b1;
                    rep_phase_d = 1'b1;
                end else if (rep_phase_q && rep_inc == C_RRATE) begin
                    rep_ev      = 1'b1;
                    rep_phase_d = 1'b1;
                end else begin
                    rep_cnt_d   = rep_inc;
                    rep_phase_d = rep_phase_q;
                end
            end
        end
`else
        assign rep_ev = 1'b0;
`endif

        assign btn_ev[i] = ev_q;
    end

    // ------------------------------------------------------------------
    // Arbiter and BCD count
    // ------------------------------------------------------------------
    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic       grant_inc_q, grant_inc_d;
    logic       grant_dec_q, grant_dec_d;
    logic       update_q, update_d;
    logic       pend_inc_q, pend_inc_d;
    logic       pend_dec_q, pend_dec_d;
    logic       ptr_q, ptr_d;

    logic       ev_inc, ev_dec;
    logic       do_inc, do_dec;
    logic [3:0] inc_tens, inc_units;
    logic [3:0] dec_tens, dec_units;

    assign ev_inc = btn_ev[BTN_INC];
    assign ev_dec = btn_ev[BTN_DEC];

    // Two-digit BCD +1 / -1 with wrap 99<->00
    always_comb begin
        if (units_q == 4'd9) begin
            inc_units = 4'd0;
            inc_tens  = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
        end else begin
            inc_units = units_q + 4'd1;
            inc_tens  = tens_q;
        end
        if (units_q == 4'd0) begin
            dec_units = 4'd9;
            dec_tens  = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
        end else begin
            dec_units = units_q - 4'd1;
            dec_tens  = tens_q;
        end
    end

    always_comb begin
        do_inc     = 1'b0;
        do_dec     = 1'b0;
        pend_inc_d = pend_inc_q;
        pend_dec_d = pend_dec_q;
        ptr_d      = ptr_q;

        // A pending loser is always served first. A new event on the side
        // being served is dropped; a new event on the other side is parked
        // in its own pending flag.
        if (pend_inc_q) begin
            do_inc     = 1'b1;
            pend_inc_d = 1'b0;
            if (ev_dec) begin
                pend_dec_d = 1'b1;
            end
        end else if (pend_dec_q) begin
            do_dec     = 1'b1;
            pend_dec_d = 1'b0;
            if (ev_inc) begin
                pend_inc_d = 1'b1;
            end
        end else if (ev_inc && ev_dec) begin
            if (ptr_q == PTR_INC) begin
                do_inc     = 1'b1;
                pend_dec_d = 1'b1;
            end else begin
                do_dec     = 1'b1;
                pend_inc_d = 1'b1;
            end
            ptr_d = ~ptr_q;
        end else if (ev_inc) begin
            do_inc = 1'b1;
        end else if (ev_dec) begin
            do_dec = 1'b1;
        end

        tens_d  = tens_q;
        units_d = units_q;
        if (do_inc) begin
            tens_d  = inc_tens;
            units_d = inc_units;
        end else if (do_dec) begin
            tens_d  = dec_tens;
            units_d = dec_units;
        end

        grant_inc_d = do_inc;
        grant_dec_d = do_dec;
        // Every grant moves the count (+-1 mod 100 never maps a value onto
        // itself), so the strobe is simply the grant delayed by one cycle.
        update_d    = grant_inc_q | grant_dec_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_q      <= 4'd0;
            units_q     <= 4'd0;
            grant_inc_q <= 1'b0;
            grant_dec_q <= 1'b0;
            update_q    <= 1'b0;
            pend_inc_q  <= 1'b0;
            pend_dec_q  <= 1'b0;
            ptr_q       <= PTR_INC;
        end else begin
            tens_q      <= tens_d;
            units_q     <= units_d;
            grant_inc_q <= grant_inc_d;
            grant_dec_q <= grant_dec_d;
            update_q    <= update_d;
            pend_inc_q  <= pend_inc_d;
            pend_dec_q  <= pend_dec_d;
            ptr_q       <= ptr_d;
        end
    end

    assign tens      = tens_q;
    assign units     = units_q;
    assign update    = update_q;
    assign grant_inc = grant_inc_q;
    assign grant_dec = grant_dec_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_counter_ctrl
//  Purpose  : Self-checking bench for bcd_counter_ctrl. Expected grants are
//             queued as buttons are pressed and popped by a monitor when the
//             DUT grants. A table of press rows walks the BCD boundaries;
//             hand sequences cover latency, bounce, collision and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_counter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_inc;
    logic       btn_dec;
    logic [3:0] tens;
    logic [3:0] units;
    logic       update;
    logic       grant_inc;
    logic       grant_dec;

    bcd_counter_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .tens      (tens),
        .units     (units),
        .update    (update),
        .grant_inc (grant_inc),
        .grant_dec (grant_dec)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_inc;
        logic [3:0] t;
        logic [3:0] u;
    } exp_t;

    typedef struct {
        bit is_inc;
        int reps;
        int exp_val;
    } row_t;

    exp_t sb_q[$];
    int   errors      = 0;
    int   checks      = 0;
    int   cyc         = 0;
    int   grant_total = 0;
    int   inc_cyc     = -1;
    int   dec_cyc     = -1;
    int   upd_cyc     = -1;
    int   model_val   = 0;
    bit   prev_grant  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain integer count modulo 100
    task automatic push_exp(input bit is_inc);
        exp_t e;
        model_val = is_inc ? (model_val + 1) % 100 : (model_val + 99) % 100;
        e.is_inc  = is_inc;
        e.t       = 4'(model_val / 10);
        e.u       = 4'(model_val % 10);
        sb_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_grant = 1'b0;
        end else begin
            if (prev_grant || update) begin
                checks++;
                if (update !== prev_grant) begin
                    errors++;
                    $display("FAIL update_strobe cyc=%0d: got %b expected %b", cyc, update, prev_grant);
                end
            end
            if (update) upd_cyc = cyc;
            if (grant_inc || grant_dec) begin
                grant_total++;
                checks++;
                if (grant_inc && grant_dec) begin
                    errors++;
                    $display("FAIL dual_grant cyc=%0d: got both grants, expected one", cyc);
                end else if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant cyc=%0d: got inc=%b dec=%b count=%0d%0d, expected none",
                             cyc, grant_inc, grant_dec, tens, units);
                end else begin
                    e = sb_q.pop_front();
                    if (grant_inc !== e.is_inc || tens !== e.t || units !== e.u) begin
                        errors++;
                        $display("FAIL grant_value cyc=%0d: got inc=%b count=%0d%0d expected inc=%b count=%0d%0d",
                                 cyc, grant_inc, tens, units, e.is_inc, e.t, e.u);
                    end
                end
                if (grant_inc) inc_cyc = cyc;
                if (grant_dec) dec_cyc = cyc;
            end
            prev_grant = grant_inc | grant_dec;
        end
    end

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_count(input string name, input int exp);
        checks++;
        if (tens !== 4'(exp / 10) || units !== 4'(exp % 10)) begin
            errors++;
            $display("FAIL %s: got %0d%0d expected %0d", name, tens, units, exp);
        end
    endtask

    // Wait (bounded) for all queued grants to appear
    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d grants outstanding expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic press(input bit is_inc, input int hold);
        @(negedge clk);
        push_exp(is_inc);
        if (is_inc) btn_inc = 1'b1; else btn_dec = 1'b1;
        repeat (hold) @(negedge clk);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        row_t rows[7];
        int   n0;
        int   g0;

        rows[0] = '{is_inc: 1'b0, reps: 1, exp_val: 0};
        rows[1] = '{is_inc: 1'b0, reps: 1, exp_val: 99};
        rows[2] = '{is_inc: 1'b1, reps: 1, exp_val: 0};
        rows[3] = '{is_inc: 1'b1, reps: 9, exp_val: 9};
        rows[4] = '{is_inc: 1'b1, reps: 1, exp_val: 10};
        rows[5] = '{is_inc: 1'b0, reps: 1, exp_val: 9};
        rows[6] = '{is_inc: 1'b0, reps: 4, exp_val: 5};

        reset   = 1'b1;
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        repeat (3) @(negedge clk);
        check_count("reset_count", 0);
        check_int("reset_grants", {30'd0, grant_inc, grant_dec}, 0);
        check_int("reset_update", {31'd0, update}, 0);
        reset = 1'b0;

        // Single press: grant at N+6, update at N+7
        @(negedge clk);
        n0 = cyc + 1;
        g0 = grant_total;
        push_exp(1'b1);
        btn_inc = 1'b1;
        repeat (10) @(negedge clk);
        btn_inc = 1'b0;
        repeat (10) @(negedge clk);
        wait_idle("single_press");
        check_int("single_grant_count", grant_total - g0, 1);
        check_int("single_grant_latency", inc_cyc - n0, 6);
        check_int("single_update_latency", upd_cyc - n0, 7);
        check_count("single_count", 1);

        // Table rows: BCD carry / borrow boundaries
        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < rows[r].reps; k++) press(rows[r].is_inc, 10);
            wait_idle("table_row");
            check_count($sformatf("table_row%0d", r), rows[r].exp_val);
        end

        // Bounce and short pulse: no event
        g0 = grant_total;
        @(negedge clk);
        #2 btn_inc = 1'b1;
        #5 btn_inc = 1'b0;
        #5 btn_inc = 1'b1;
        #5 btn_inc = 1'b0;
        #5 btn_inc = 1'b1;
        #10 btn_inc = 1'b0;
        repeat (10) @(negedge clk);
        #2 btn_inc = 1'b1;
        #15 btn_inc = 1'b0;
        repeat (12) @(negedge clk);
        check_int("bounce_no_grant", grant_total - g0, 0);
        check_count("bounce_count", 5);

        // Collision 1: inc wins, dec one edge later
        @(negedge clk);
        push_exp(1'b1);
        push_exp(1'b0);
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        repeat (10) @(negedge clk);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        repeat (10) @(negedge clk);
        wait_idle("collision1");
        check_int("collision1_order", dec_cyc - inc_cyc, 1);
        check_count("collision1_count", 5);

        // Collision 2: pointer toggled, dec wins
        @(negedge clk);
        push_exp(1'b0);
        push_exp(1'b1);
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        repeat (10) @(negedge clk);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        repeat (10) @(negedge clk);
        wait_idle("collision2");
        check_int("collision2_order", inc_cyc - dec_cyc, 1);
        check_count("collision2_count", 5);

        // Reset in the middle of a held press
        @(negedge clk);
        push_exp(1'b1);
        btn_inc = 1'b1;
        repeat (10) @(negedge clk);
        wait_idle("pre_reset_press");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_count("midreset_count", 0);
        check_int("midreset_outputs", {29'd0, grant_inc, grant_dec, update}, 0);
        model_val = 0;
        g0 = grant_total;
        reset = 1'b0;
        n0 = cyc + 1;
        push_exp(1'b1);
        repeat (10) @(negedge clk);
        btn_inc = 1'b0;
        repeat (10) @(negedge clk);
        wait_idle("post_reset_press");
        check_int("post_reset_grants", grant_total - g0, 1);
        check_int("post_reset_grant_latency", inc_cyc - n0, 6);
        check_int("post_reset_update_latency", upd_cyc - n0, 7);
        check_count("post_reset_count", 1);

`ifdef AUTOREPEAT_EN
        // Auto-repeat: hold ~60 cycles past PRESSED entry -> 7 increments
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_val = 0;
        g0 = grant_total;
        for (int k = 0; k < 7; k++) push_exp(1'b1);
        btn_inc = 1'b1;
        repeat (64) @(negedge clk);
        btn_inc = 1'b0;
        repeat (12) @(negedge clk);
        wait_idle("autorepeat");
        check_int("autorepeat_grants", grant_total - g0, 7);
        check_count("autorepeat_count", 7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
